// File: rtl/dma_desc_splitter.sv
// Descriptor splitter: pops DMA descriptors from the FIFO head and issues
// read requests that never exceed MAX_BYTES or cross a MAX_BYTES boundary.
module dma_desc_splitter #(
    parameter int MAX_BYTES = 128
) (
    input  logic        clockCore,
    input  logic        resetCore,
    input  logic        fifoEmpty,
    input  logic [55:0] fifoDataOut,
    output logic        fifoPop,
    output logic        reqValid,
    input  logic        reqReady,
    output logic [31:0] reqAddr,
    output logic [12:0] reqLen,
    output logic        reqLast,
    output logic        busy,
    output logic        descDone,
    output logic        zeroLenErr
);
    localparam int OFFW = $clog2(MAX_BYTES);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t      state;
    logic [31:0] curAddr;
    logic [23:0] remain;
    logic [OFFW-1:0] offset;
    logic [12:0] room;
    logic [12:0] chunk;
    logic [23:0] popLen;
    logic        handshake;

    // room is 1..MAX_BYTES, so it always fits 13 bits even at 4096
    assign offset    = curAddr[OFFW-1:0];
    assign room      = 13'(MAX_BYTES) - 13'(offset);
    assign chunk     = (remain < 24'(room)) ? remain[12:0] : room;
    assign reqAddr   = curAddr;
    assign reqLen    = chunk;
    assign reqLast   = (remain == 24'(chunk));
    assign popLen    = fifoDataOut[23:0];
    assign handshake = reqValid && reqReady;
    assign fifoPop   = !resetCore && (state == IDLE) && !fifoEmpty;

    always_ff @(posedge clockCore) begin
        if (resetCore) begin
            state      <= IDLE;
            curAddr    <= '0;
            remain     <= '0;
            reqValid   <= 1'b0;
            busy       <= 1'b0;
            descDone   <= 1'b0;
            zeroLenErr <= 1'b0;
        end else begin
            descDone   <= 1'b0;
            zeroLenErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifoPop) begin
                        if (popLen != 24'd0) begin
                            curAddr  <= fifoDataOut[55:24];
                            remain   <= popLen;
                            reqValid <= 1'b1;
                            busy     <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            zeroLenErr <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        curAddr <= curAddr + 32'(chunk);
                        remain  <= remain - 24'(chunk);
                        if (reqLast) begin
                            reqValid <= 1'b0;
                            busy     <= 1'b0;
                            descDone <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dma_desc_splitter.md
# dma_desc_splitter

Reader end of the 8-deep × 56-bit descriptor register FIFO. It pops one DMA descriptor at a time from the FIFO head and splits it into a sequence of read requests. Each request is at most `MAX_BYTES` long and never crosses a `MAX_BYTES`-aligned boundary. The requests are presented on a valid/ready interface to the PCIe request generator.

## Interface
Parameters:
- `MAX_BYTES`, 128: maximum request size in bytes. Must be a power of two, 64..4096.

Ports:
- `clockCore`  in  1  single clock; all logic is on its rising edge.
- `resetCore`  in  1  reset, synchronous and active-high.
- `fifoEmpty`  in  1  FIFO empty flag.
- `fifoDataOut`  in  56  FIFO head word, first-word fall-through. Valid whenever `fifoEmpty`=0. Fields: [55:24] byte address, [23:0] byte length.
- `fifoPop`  out  1  pops the FIFO head this cycle.
- `reqValid`  out  1  request valid.
- `reqReady`  in  1  downstream accepts the request.
- `reqAddr`  out  32  request byte address.
- `reqLen`  out  13  request byte length, 1..`MAX_BYTES`.
- `reqLast`  out  1  this is the final request of the descriptor.
- `busy`  out  1  a descriptor is in progress.
- `descDone`  out  1  one-cycle pulse after the last request is accepted.
- `zeroLenErr`  out  1  one-cycle pulse when a zero-length descriptor is popped.

## Operation
- Internal registers: `curAddr`[31:0] and `remain`[23:0].
- Chunk calculation:
  - `room` = `MAX_BYTES` − (`curAddr` mod `MAX_BYTES`).
  - `chunk` = min(`remain`, `room`).
  - `reqLen` = `chunk`, `reqAddr` = `curAddr`, `reqLast` = (`remain` == `chunk`).
- Two-state FSM:
  - **IDLE**
    - `fifoPop` = !`fifoEmpty` (combinational).
    - On a pop with length ≠ 0: load `curAddr` and `remain` from `fifoDataOut`, go to ISSUE.
    - On a pop with length = 0: pulse `zeroLenErr` next cycle, stay in IDLE. No request is issued.
  - **ISSUE**
    - `reqValid` = 1.
    - On handshake (`reqValid` & `reqReady`): `curAddr` += `chunk`, `remain` −= `chunk`.
    - If `reqLast` was set on that handshake: go to IDLE and pulse `descDone` the next cycle.
- `busy` = (state == ISSUE).
- Address arithmetic is modulo 2^32; the address wraps silently from 0xFFFFFFFF to 0.
- `fifoPop` is never asserted in ISSUE. The FIFO underrun flag must therefore never fire because of this block.
- When `reqValid`=1 and `reqReady`=0, `reqAddr`, `reqLen` and `reqLast` hold stable. `reqValid` does not drop until the handshake completes.

## Timing
- Reset values:
  - State IDLE.
  - `reqValid`=0, `descDone`=0, `zeroLenErr`=0, `busy`=0.
  - `curAddr`=0, `remain`=0. Consequently `reqAddr`=0 and `reqLen`=0 while in IDLE.
  - `fifoPop` is forced to 0 while `resetCore`=1.
- Asserting `resetCore` in ISSUE aborts the descriptor:
  - `reqValid` is 0 on the next cycle.
  - The remaining chunks are discarded; no `descDone` is issued.
- Latency:
  - `fifoEmpty` falls in cycle N while in IDLE → `fifoPop`=1 in cycle N → `reqValid`=1 in cycle N+1.
  - Last handshake in cycle M → state is IDLE in M+1, with `descDone`=1 in M+1 → next pop no earlier than M+1 → next `reqValid` no earlier than M+2.
- Throughput: one request per cycle while `reqReady`=1.
- `descDone` and `zeroLenErr` never assert in the same cycle.

## Test plan
- **Aligned split.** `MAX_BYTES`=128, descriptor addr 0x00001000, len 0x100, `reqReady`=1 → (0x1000, 128, last=0), then (0x1080, 128, last=1). `descDone` one cycle after the second request.
- **Unaligned head.** Descriptor addr 0x000001F0, len 0x30 → (0x1F0, 16, last=0), then (0x200, 32, last=1).
- **Backpressure.** Descriptor addr 0x0, len 0x180. Hold `reqReady`=0 for 5 cycles per request → outputs stable while stalled, exactly 3 requests, `fifoPop` asserted exactly once.
- **Zero length followed by a normal descriptor.** Descriptors len 0, then addr 0x40, len 4 → `zeroLenErr` pulse, no request for the first; then the second descriptor gives (0x40, 4, last=1).
- **Address wrap and back-to-back.** Two descriptors queued: addr 0xFFFFFFC0, len 0x80, then addr 0x2000, len 8 → (0xFFFFFFC0, 64), (0x00000000, 64, last), then the second descriptor's request two cycles after the previous last handshake.
- **Reset mid-descriptor.** Assert `resetCore` after the first of 3 handshakes → next cycle `reqValid`=0 and `busy`=0, no `descDone`. After reset is released, the next FIFO descriptor is processed normally.
